// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the threshold-tuning command link (host sender and remote controller).
package uart_cmd_pkg;

  localparam logic [7:0] MODE_BASE = 8'h41; // 'A'
  localparam logic [7:0] CMD_INC   = 8'h77; // 'w'
  localparam logic [7:0] CMD_DEC   = 8'h73; // 's'
  localparam int         NUM_MODES = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_MODE,
    ST_WAIT_MODE,
    ST_SEND_DIR,
    ST_WAIT_DIR
  } cmd_state_e;

  function automatic logic mode_valid(input logic [3:0] m);
    return m < 4'(NUM_MODES);
  endfunction

  function automatic logic [7:0] mode_byte(input logic [3:0] m);
    return MODE_BASE + {4'h0, m};
  endfunction

endpackage

// File: rtl/uart_echo_timer.sv
// Echo wait timer: cleared on demand, counts while enabled, saturates at ECHO_TIMEOUT.
module uart_echo_timer #(
  parameter int ECHO_TIMEOUT = 200000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            TW    = $clog2(ECHO_TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(ECHO_TIMEOUT);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      cnt_q <= '0;
    else if (clr_i)                   cnt_q <= '0;
    else if (en_i && cnt_q != LIMIT)  cnt_q <= cnt_q + 1'b1;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_sender.sv
// Turns a panel request into mode/adjust bytes for the threshold controller.
// UART_CMD_ECHO_CHECK_EN enables echo checking, timeouts and mode-byte retries.
module uart_cmd_sender
  import uart_cmd_pkg::*;
#(
  parameter int ECHO_TIMEOUT = 200000,
  parameter int MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_mode,
  input  logic       req_dir,
  input  logic       idle_ready_tx,
  output logic       start_tx,
  output logic [7:0] data_tx,
  input  logic       data_ready_rx,
  input  logic [7:0] data_rx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int            RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  cmd_state_e    state_q;
  logic [7:0]    mode_byte_q, dir_byte_q, cache_q, data_tx_q;
  logic [RW-1:0] retry_q;
  logic          start_tx_q, done_q, err_q;

  logic [7:0] req_mb, req_db, want_byte;
  logic       tx_ok, in_wait, want_tx, want_mode;
  logic       mode_done, dir_done, expired_w, tmr_expired;

  assign req_mb  = mode_byte(req_mode);
  assign req_db  = req_dir ? CMD_INC : CMD_DEC;
  // The UART's idle flag lags a strobe by a cycle, so never fire back to back.
  assign tx_ok   = idle_ready_tx && !start_tx_q;
  assign in_wait = (state_q == ST_WAIT_MODE) || (state_q == ST_WAIT_DIR);

`ifdef UART_CMD_ECHO_CHECK_EN
  logic echo_hit;
  assign echo_hit  = data_ready_rx && (data_rx == data_tx_q);
  assign mode_done = echo_hit;
  assign dir_done  = echo_hit;
  assign expired_w = tmr_expired;
`else
  logic unused_rx;
  assign unused_rx = ^{data_ready_rx, data_rx, tmr_expired};
  assign mode_done = tx_ok;
  assign dir_done  = tx_ok;
  assign expired_w = 1'b0;
`endif

  uart_echo_timer #(.ECHO_TIMEOUT(ECHO_TIMEOUT)) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (!in_wait || want_tx),
    .en_i      (in_wait),
    .expired_o (tmr_expired)
  );

  // Which byte (if any) the FSM wants on the wire this cycle; fired directly when the UART allows.
  always_comb begin
    want_tx   = 1'b0;
    want_mode = 1'b0;
    want_byte = dir_byte_q;
    unique case (state_q)
      ST_IDLE: if (req_valid && mode_valid(req_mode)) begin
        want_tx   = 1'b1;
        want_mode = (req_mb != cache_q);
        want_byte = want_mode ? req_mb : req_db;
      end
      ST_SEND_MODE: begin
        want_tx   = 1'b1;
        want_mode = 1'b1;
        want_byte = mode_byte_q;
      end
      ST_SEND_DIR: want_tx = 1'b1;
      ST_WAIT_MODE: begin
        if (mode_done) want_tx = 1'b1;
        else if (expired_w && retry_q < RETRY_LIM) begin
          want_tx   = 1'b1;
          want_mode = 1'b1;
          want_byte = mode_byte_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_byte_q <= MODE_BASE;
      dir_byte_q  <= CMD_DEC;
      cache_q     <= MODE_BASE;
      retry_q     <= '0;
      start_tx_q  <= 1'b0;
      data_tx_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_tx_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (want_tx) begin
        if (tx_ok) begin
          start_tx_q <= 1'b1;
          data_tx_q  <= want_byte;
          state_q    <= want_mode ? ST_WAIT_MODE : ST_WAIT_DIR;
`ifndef UART_CMD_ECHO_CHECK_EN
          if (want_mode) cache_q <= want_byte;
`endif
        end else begin
          state_q <= want_mode ? ST_SEND_MODE : ST_SEND_DIR;
        end
      end
      unique case (state_q)
        ST_IDLE: if (req_valid) begin
          if (!mode_valid(req_mode)) err_q <= 1'b1;
          else begin
            mode_byte_q <= req_mb;
            dir_byte_q  <= req_db;
            retry_q     <= '0;
          end
        end
        ST_WAIT_MODE: begin
          if (mode_done) begin
`ifdef UART_CMD_ECHO_CHECK_EN
            cache_q <= mode_byte_q;
`endif
          end else if (expired_w) begin
            if (retry_q < RETRY_LIM) retry_q <= retry_q + 1'b1;
            else begin
              // Controller state unknown: force the mode byte out on the next request.
              err_q   <= 1'b1;
              cache_q <= 8'h00;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WAIT_DIR: begin
          if (dir_done) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (expired_w) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_tx  = start_tx_q;
  assign data_tx   = data_tx_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign req_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Bench for uart_cmd_sender: directed and random requests scored against a transaction-level model
// of the link. Expectations follow UART_CMD_ECHO_CHECK_EN the same way the design does.
module tb_uart_cmd_sender;

  localparam int TO = 16;
  localparam int MR = 2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_dir = 1'b0;
  logic [3:0] req_mode = 4'd0;
  logic       idle_ready_tx = 1'b1, start_tx;
  logic [7:0] data_tx;
  logic       data_ready_rx = 1'b0;
  logic [7:0] data_rx = 8'h00;
  logic       busy, done, err;

  int n_chk = 0, n_fail = 0;

  uart_cmd_sender #(.ECHO_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_dir(req_dir), .idle_ready_tx(idle_ready_tx),
    .start_tx(start_tx), .data_tx(data_tx), .data_ready_rx(data_ready_rx),
    .data_rx(data_rx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_mode(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h49);
  endfunction

  // Link environment: UART transmitter, remote echo, pulse monitor (all on the falling edge).
  int         cyc = 0, tx_left = 0, tx_len_fix = 0, rx_wait = 0;
  int         dn_cnt = 0, er_cnt = 0, dn_at = 0, er_at = 0, idle_at = 0, echo_at = 0;
  int         force_at = -1, force_off = 0;
  logic [7:0] force_byte = 8'h00, cur_tx = 8'h00;
  logic       prev_start = 1'b0, drop_mode = 1'b0, drop_dir = 1'b0, noise = 1'b0, rescue = 1'b0;
  logic [7:0] tx_seen[$], rxq[$];
  int         tx_at[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (done) begin dn_cnt++; dn_at = cyc; end
    if (err)  begin er_cnt++; er_at = cyc; end
    if (start_tx) begin
      chk("tx_while_busy", {31'd0, idle_ready_tx}, 32'd1);
      chk("tx_back_to_back", {31'd0, prev_start}, 32'd0);
      tx_seen.push_back(data_tx);
      tx_at.push_back(cyc);
      cur_tx = data_tx;
      if (force_off > 0 && is_mode(data_tx)) begin
        force_at = cyc + force_off; force_byte = data_tx; force_off = 0;
      end
      idle_ready_tx = 1'b0;
      tx_left = (tx_len_fix > 0) ? tx_len_fix : int'($urandom_range(1, 5));
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin
        idle_ready_tx = 1'b1;
        idle_at = cyc;
        if (!(is_mode(cur_tx) ? drop_mode : drop_dir)) begin
          if (noise) rxq.push_back(cur_tx ^ 8'h20);
          rxq.push_back(cur_tx);
          rx_wait = $urandom_range(0, 2);
        end
      end
    end
    prev_start = start_tx;
    if (data_ready_rx) data_ready_rx = 1'b0;
    else if (cyc == force_at) begin
      data_ready_rx = 1'b1; data_rx = force_byte;
    end else if (rxq.size() > 0) begin
      if (rx_wait > 0) rx_wait--;
      else begin
        data_rx = rxq.pop_front(); data_ready_rx = 1'b1; echo_at = cyc;
      end
    end
  end

  // Reference model: bytes the controller should see and how the request should end.
  logic [7:0] cache_m = 8'h41;
  logic [7:0] exp_b[$];
  int         exp_out;   // 1 = done, 2 = err
  logic       exp_retry;

  task automatic model(input logic [3:0] m, input logic d);
    logic [7:0] mb, db;
    exp_b.delete();
    exp_retry = 1'b0;
    if (m > 4'd8) begin exp_out = 2; return; end
    mb = 8'h41 + 8'(m);
    db = d ? 8'h77 : 8'h73;
`ifdef UART_CMD_ECHO_CHECK_EN
    if (mb != cache_m && drop_mode && !rescue) begin
      repeat (MR + 1) exp_b.push_back(mb);
      cache_m = 8'h00; exp_out = 2; exp_retry = 1'b1;
      return;
    end
`endif
    if (mb != cache_m) exp_b.push_back(mb);
    cache_m = mb;
    exp_b.push_back(db);
`ifdef UART_CMD_ECHO_CHECK_EN
    exp_out = drop_dir ? 2 : 1;
`else
    exp_out = 1;
`endif
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_quiet();
    int k = 0;
    while (!(req_ready && idle_ready_tx && rxq.size() == 0 && !data_ready_rx) && k < 300) begin
      step(); k++;
    end
    chk("quiet_timeout", {31'd0, k >= 300}, 32'd0);
  endtask

  task automatic run_req(input logic [3:0] m, input logic d);
    int acc, dn0, er0, k;
    model(m, d);
    wait_quiet();
    tx_seen.delete(); tx_at.delete();
    dn0 = dn_cnt; er0 = er_cnt;
    req_valid = 1'b1; req_mode = m; req_dir = d;
    acc = cyc + 1;
    step();
    req_valid = 1'b0;
    req_mode = 4'($urandom); req_dir = 1'($urandom);
    if (exp_b.size() == 0) chk("ready_after_invalid", {31'd0, req_ready}, 32'd1);
    k = 0;
    while (dn_cnt == dn0 && er_cnt == er0 && k < 400) begin step(); k++; end
    chk("req_timeout", {31'd0, k >= 400}, 32'd0);
    repeat (4) step();
    chk("n_bytes", tx_seen.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < tx_seen.size(); i++) chk("byte", {24'd0, tx_seen[i]}, {24'd0, exp_b[i]});
    chk("done_pulses", dn_cnt - dn0, (exp_out == 1) ? 32'd1 : 32'd0);
    chk("err_pulses", er_cnt - er0, (exp_out == 2) ? 32'd1 : 32'd0);
    if (exp_b.size() > 0 && tx_at.size() > 0) chk("start_latency", tx_at[0], acc + 1);
    if (exp_b.size() == 0) chk("invalid_err_latency", er_at, acc + 1);
    if (exp_retry) for (int i = 1; i < tx_at.size(); i++) chk("retry_gap", tx_at[i] - tx_at[i-1], TO + 1);
`ifdef UART_CMD_ECHO_CHECK_EN
    if (exp_out == 1) chk("done_latency", dn_at, echo_at + 1);
`else
    if (exp_out == 1) chk("done_latency", dn_at, idle_at + 1);
`endif
    chk("idle_after", {30'd0, busy, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dn0;
    #12;
    chk("rst_start_tx", {31'd0, start_tx}, 32'd0);
    chk("rst_data_tx", {24'd0, data_tx}, 32'd0);
    chk("rst_busy_ready", {30'd0, busy, req_ready}, 32'd1);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_req(4'd0, 1'b1);                  // cached 'A': only 'w'
    run_req(4'd3, 1'b0);                  // 'D' then 's'
    run_req(4'd3, 1'b0);                  // 's' only
    drop_mode = 1'b1;
    run_req(4'd5, 1'b1);                  // 'F' retried, then err
    drop_mode = 1'b0;
    run_req(4'd5, 1'b1);                  // mode byte resent
    run_req(4'd1, 1'b0);
    drop_mode = 1'b1; rescue = 1'b1; force_off = TO;
    run_req(4'd5, 1'b0);                  // echo lands on the expiry cycle
    drop_mode = 1'b0; rescue = 1'b0; force_off = 0;
    run_req(4'd12, 1'b1);                 // invalid channel

    // Reset while waiting for the adjust echo.
    wait_quiet();
    drop_dir = 1'b1; tx_len_fix = 12;
    tx_seen.delete(); tx_at.delete();
    req_valid = 1'b1; req_mode = 4'd5; req_dir = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 50 && tx_seen.size() == 0; k++) step();
    chk("rst_test_sent", tx_seen.size(), 32'd1);
    repeat (2) step();
    chk("busy_in_wait_dir", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data_tx", {24'd0, data_tx}, 32'd0);
    chk("async_rst_busy_ready", {30'd0, busy, req_ready}, 32'd1);
    chk("async_rst_pulses", {29'd0, start_tx, done, err}, 32'd0);
    step();
    rst_n = 1'b1;
    cache_m = 8'h41; drop_dir = 1'b0; tx_len_fix = 0;
    dn0 = dn_cnt;
    force_at = cyc + 2; force_byte = 8'h77;
    repeat (5) step();
    chk("echo_after_reset", dn_cnt - dn0, 32'd0);
    run_req(4'd0, 1'b1);                  // cache back to 'A'

    for (int n = 0; n < 40; n++) begin
      drop_mode = ($urandom_range(0, 4) == 0);
      drop_dir  = ($urandom_range(0, 5) == 0);
      noise     = ($urandom_range(0, 2) == 0);
      run_req(4'($urandom_range(0, 10)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
